// File: rtl/sao_pkg.sv
// sao_pkg: shared encodings, rate constants and FSM states for the SAO RDO scheduler.
package sao_pkg;
   localparam logic [2:0] SAO_OFF = 3'd0;
   localparam logic [2:0] SAO_EO0 = 3'd1;
   localparam logic [2:0] SAO_EO1 = 3'd2;
   localparam logic [2:0] SAO_EO2 = 3'd3;
   localparam logic [2:0] SAO_EO3 = 3'd4;
   localparam logic [2:0] SAO_BO  = 3'd5;
   localparam logic [1:0] SAO_MODE_OFF = 2'd0;
   localparam logic [1:0] SAO_MODE_NEW = 2'd1;
   localparam int OFFSET_MAX = 7;
   localparam int EO_RATE = 2;
   localparam int BO_RATE = 5;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_LOAD = 3'd1;
   localparam state_t S_DIV  = 3'd2;
   localparam state_t S_ACC  = 3'd3;
   localparam state_t S_BOW  = 3'd4;
   localparam state_t S_DEC  = 3'd5;
endpackage

// File: rtl/sao_offset_div.sv
// sao_offset_div: restoring divider giving sign(s)*floor((2|s|+n)/(2n)) saturated to +-OFFSET_MAX; 0 when n==0.
module sao_offset_div import sao_pkg::*; #(
   parameter int SW = 14,
   parameter int NW = 10,
   parameter int OL = 4
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 start,
   input  logic signed [SW-1:0] s,
   input  logic [NW-1:0]        n,
   output logic                 valid,
   output logic signed [OL-1:0] q
);
   localparam int RW = SW + 3;
   logic [RW-1:0] r, dv, num0, d8;
   logic [SW-1:0] a;
   logic [3:0] qq;
   logic [2:0] mag;
   logic [1:0] cnt;
   logic neg, nz, run, ge3, ge;
   // bit 3 is resolved on the start edge; it flags a quotient >= 8, i.e. saturation
   always_comb begin
      a = s[SW-1] ? SW'(-s) : SW'(s);
      num0 = RW'({a, 1'b0}) + RW'(n);
      d8 = RW'({n, 4'b0});
      ge3 = num0 >= d8;
      ge = r >= dv;
      mag = qq[3] ? 3'(OFFSET_MAX) : qq[2:0];
      q = !nz ? '0 : neg ? -OL'({1'b0, mag}) : OL'({1'b0, mag});
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r <= '0;
         dv <= '0;
         qq <= '0;
         cnt <= '0;
         neg <= 1'b0;
         nz <= 1'b0;
         run <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (start) begin
            r <= ge3 ? num0 - d8 : num0;
            dv <= RW'({n, 3'b0});
            qq <= {3'b0, ge3};
            cnt <= 2'd2;
            neg <= s[SW-1];
            nz <= |n;
            run <= 1'b1;
         end else if (run) begin
            r <= ge ? r - dv : r;
            dv <= dv >> 1;
            qq <= {qq[2:0], ge};
            cnt <= cnt - 2'd1;
            if (cnt == 2'd0) begin
               run <= 1'b0;
               valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/sao_rdo_sched.sv
// sao_rdo_sched: per-CTU SAO RDO decision (OFF / EO class / BO window).
// SAO_EARLY_TERM_EN: entries with n==0 finish in their LOAD cycle instead of LOAD/DIV/ACC.
module sao_rdo_sched import sao_pkg::*; #(
   parameter int DIFF_CLIP_BIT = 4,
   parameter int NUM_ACCU_LEN  = 9,
   parameter int N_EO_TYPE     = 4,
   parameter int N_CATEGORY    = 4,
   parameter int N_CATEGORY_BO = 8,
   parameter int OFFSET_LEN    = 4,
   parameter int COST_LEN      = 24
) (
   input  logic clk,
   input  logic arst_n,
   input  logic start,
   input  logic [1:0] comp_idx,
   input  logic [2:0][NUM_ACCU_LEN-1:0] lamda,
   input  logic [N_EO_TYPE-1:0][N_CATEGORY-1:0][NUM_ACCU_LEN+DIFF_CLIP_BIT:0] sum_eo,
   input  logic [N_EO_TYPE-1:0][N_CATEGORY-1:0][NUM_ACCU_LEN:0] num_eo,
   input  logic [N_CATEGORY_BO-1:0][NUM_ACCU_LEN+DIFF_CLIP_BIT:0] sum_bo,
   input  logic [N_CATEGORY_BO-1:0][NUM_ACCU_LEN:0] num_bo,
   output logic busy,
   output logic done,
   output logic [2:0] sao_type,
   output logic [1:0] sao_mode,
   output logic [N_CATEGORY-1:0][OFFSET_LEN-1:0] offset,
   output logic [4:0] type_aux,
   output logic signed [COST_LEN-1:0] best_cost
);
   localparam int SW = NUM_ACCU_LEN + DIFF_CLIP_BIT + 1;
   localparam int NW = NUM_ACCU_LEN + 1;
   localparam int OL = OFFSET_LEN;
   localparam int CW = COST_LEN;
   localparam int NE = N_EO_TYPE * N_CATEGORY + N_CATEGORY_BO;
   state_t state;
   logic [4:0] e;
   logic [2:0] w, btype, baux, eo_type, abs_o;
   logic [NUM_ACCU_LEN-1:0] lam;
   logic signed [SW-1:0] s_sel;
   logic [NW-1:0] n_sel;
   logic signed [OL-1:0] dq, q_eff, o;
   logic signed [CW-1:0] dn, ds, dov, da, lam_c, jd, jc, base, best, cand_eo, cand_bo;
   logic [2:0][OL-1:0] cur;
   logic [N_CATEGORY-1:0][OL-1:0] boff;
   logic [N_CATEGORY_BO-1:0][OL-1:0] bo_o;
   logic signed [CW-1:0] bo_j [N_CATEGORY_BO];
   logic skip, div_go, div_valid, acc, last;
`ifdef SAO_EARLY_TERM_EN
   assign skip = (state == S_LOAD) && (n_sel == '0);
`else
   assign skip = 1'b0;
`endif
   assign busy = state != S_IDLE;
   // jd already folds in the lambda*|o| rate term, so class and window costs are plain sums
   always_comb begin
      lam = (comp_idx == 2'd3) ? '0 : lamda[comp_idx];
      s_sel = e[4] ? $signed(sum_bo[e[2:0]]) : $signed(sum_eo[e[3:2]][e[1:0]]);
      n_sel = e[4] ? num_bo[e[2:0]] : num_eo[e[3:2]][e[1:0]];
      q_eff = (n_sel == '0) ? '0 : dq;
      o = e[4] ? q_eff : e[1] ? (q_eff[OL-1] ? q_eff : '0) : (q_eff[OL-1] ? '0 : q_eff);
      abs_o = o[OL-1] ? 3'(-o) : 3'(o);
      dn = CW'(n_sel);
      ds = CW'(s_sel);
      dov = CW'(o);
      da = CW'(abs_o);
      lam_c = CW'(lam);
      jd = dn * dov * dov - ((dov * ds) <<< 1) + lam_c * da;
      base = (e[1:0] == 2'd0) ? lam_c * CW'(EO_RATE) : jc;
      cand_eo = base + jd;
      cand_bo = bo_j[w] + bo_j[w + 3'd1] + bo_j[w + 3'd2] + bo_j[w + 3'd3] + lam_c * CW'(BO_RATE);
      eo_type = (e[3:2] == 2'd0) ? SAO_EO0 : (e[3:2] == 2'd1) ? SAO_EO1 : (e[3:2] == 2'd2) ? SAO_EO2 : SAO_EO3;
      last = e == 5'(NE - 1);
      div_go = (state == S_LOAD) && !skip;
      acc = (state == S_ACC) || skip;
   end
   sao_offset_div #(.SW(SW), .NW(NW), .OL(OL)) u_div (
      .clk(clk), .arst_n(arst_n), .start(div_go), .s(s_sel), .n(n_sel), .valid(div_valid), .q(dq)
   );
   // strict < keeps the earlier candidate on ties: OFF, then EO0..EO3, then BO by window
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= S_IDLE;
         e <= '0;
         w <= '0;
         jc <= '0;
         best <= '0;
         btype <= SAO_OFF;
         baux <= '0;
         cur <= '0;
         boff <= '0;
         bo_o <= '0;
         for (int i = 0; i < N_CATEGORY_BO; i++) bo_j[i] <= '0;
         done <= 1'b0;
         sao_type <= SAO_OFF;
         sao_mode <= SAO_MODE_OFF;
         offset <= '0;
         type_aux <= '0;
         best_cost <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               state <= S_LOAD;
               e <= '0;
               best <= '0;
               btype <= SAO_OFF;
               baux <= '0;
               boff <= '0;
            end
            S_LOAD: if (!skip) state <= S_DIV;
            S_DIV: if (div_valid) state <= S_ACC;
            S_BOW: begin
               if (cand_bo < best) begin
                  best <= cand_bo;
                  btype <= SAO_BO;
                  baux <= w;
                  boff <= {bo_o[w + 3'd3], bo_o[w + 3'd2], bo_o[w + 3'd1], bo_o[w]};
               end
               w <= w + 3'd1;
               if (w == 3'd4) state <= S_DEC;
            end
            S_DEC: begin
               sao_type <= btype;
               sao_mode <= (btype == SAO_OFF) ? SAO_MODE_OFF : SAO_MODE_NEW;
               offset <= boff;
               type_aux <= {2'b0, baux};
               best_cost <= best;
               done <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (acc) begin
            if (e[4]) begin
               bo_j[e[2:0]] <= jd;
               bo_o[e[2:0]] <= o;
            end else begin
               if (e[1:0] != 2'd3) cur[e[1:0]] <= o;
               jc <= cand_eo;
               if (e[1:0] == 2'd3 && cand_eo < best) begin
                  best <= cand_eo;
                  btype <= eo_type;
                  baux <= '0;
                  boff <= {o, cur};
               end
            end
            e <= e + 5'd1;
            w <= '0;
            state <= last ? S_BOW : S_LOAD;
         end
      end
   end
endmodule
